// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, queue depth default and queue entry type for the write-back stage
package wb_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] dir;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/write_back_queue_if.sv
// rtl/write_back_queue_if.sv - producer, register-file and forwarding signals of the write-back stage
interface write_back_queue_if;
  import wb_pkg::*;

  logic              alu_wr;
  logic [ADDR_W-1:0] alu_dir;
  logic [DATA_W-1:0] alu_data;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_dir;
  logic [DATA_W-1:0] mem_data;
  logic              stall;
  logic              reg_wr_out;
  logic [ADDR_W-1:0] dir_wb_out;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] fwd_dir;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              ovf_err;

  modport master (
    output alu_wr, alu_dir, alu_data, mem_wr, mem_dir, mem_data, fwd_dir,
    input  stall, reg_wr_out, dir_wb_out, data_out, fwd_hit, fwd_data, ovf_err
  );

  modport slave (
    input  alu_wr, alu_dir, alu_data, mem_wr, mem_dir, mem_data, fwd_dir,
    output stall, reg_wr_out, dir_wb_out, data_out, fwd_hit, fwd_data, ovf_err
  );
endinterface

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - dual-push / single-pop result queue with pass-through head and overflow drop
module wb_fifo2
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mem_wr,
  input  wb_entry_t                         mem_entry,
  input  logic                              alu_wr,
  input  wb_entry_t                         alu_entry,
  output logic                              pop,
  output wb_entry_t                         head,
  output logic                              drop,
  output logic [$clog2(DEPTH):0]            count,
  output logic [$clog2(DEPTH)-1:0]          rd_ptr,
  output wb_entry_t [DEPTH-1:0]             entries
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = CW + 1;

  wb_entry_t [DEPTH-1:0] store;
  logic [PW-1:0]         wr_ptr;
  logic [FW-1:0]         free;
  logic                  acc_mem;
  logic                  acc_alu;

  // A non-empty queue always pops this cycle, so its head slot counts as free space.
  assign free    = FW'(DEPTH) - {1'b0, count} + FW'(count != '0);
  assign acc_mem = mem_wr && (free >= FW'(1));
  assign acc_alu = alu_wr && (free >= (acc_mem ? FW'(2) : FW'(1)));
  assign drop    = (mem_wr && !acc_mem) || (alu_wr && !acc_alu);
  assign pop     = (count != '0) || acc_mem || acc_alu;
  assign head    = (count != '0) ? store[rd_ptr] : (acc_mem ? mem_entry : alu_entry);
  assign entries = store;

  always_ff @(posedge clk) begin
    if (acc_mem) store[wr_ptr] <= mem_entry;
    if (acc_alu) store[wr_ptr + PW'(acc_mem)] <= alu_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(acc_mem) + PW'(acc_alu);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(acc_mem) + CW'(acc_alu) - CW'(pop);
    end
  end
endmodule

// File: rtl/write_back_queue.sv
// rtl/write_back_queue.sv - write-back stage: result queue, register-file write port, forwarding lookup
module write_back_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  write_back_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t             mem_e;
  wb_entry_t             alu_e;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  pop;
  logic                  drop;

  assign mem_e = '{dir: bus.mem_dir, data: bus.mem_data};
  assign alu_e = '{dir: bus.alu_dir, data: bus.alu_data};

  wb_fifo2 #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .mem_wr    (bus.mem_wr),
    .mem_entry (mem_e),
    .alu_wr    (bus.alu_wr),
    .alu_entry (alu_e),
    .pop       (pop),
    .head      (head),
    .drop      (drop),
    .count     (count),
    .rd_ptr    (rd_ptr),
    .entries   (entries)
  );

  assign bus.stall = (count >= CW'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.reg_wr_out <= 1'b0;
      bus.dir_wb_out <= '0;
      bus.data_out   <= '0;
      bus.ovf_err    <= 1'b0;
    end else begin
      bus.reg_wr_out <= pop;
      if (pop) begin
        bus.dir_wb_out <= head.dir;
        bus.data_out   <= head.data;
      end
      if (drop) bus.ovf_err <= 1'b1;
    end
  end

  // Scan oldest to youngest so the youngest matching write is the one left standing.
  always_comb begin
    logic [PW-1:0] idx;
    idx          = '0;
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    if (bus.reg_wr_out && (bus.dir_wb_out == bus.fwd_dir)) begin
      bus.fwd_hit  = 1'b1;
      bus.fwd_data = bus.data_out;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (entries[idx].dir == bus.fwd_dir)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = entries[idx].data;
      end
    end
  end
endmodule
